frwrd_ramp_ctrl: RTL and testbench



---
 rtl/frwrd_ramp_pkg.sv | 34 +++
 rtl/frwrd_ramp_ctrl_sat_step.sv | 26 ++
 rtl/frwrd_ramp_ctrl.sv | 123 ++++++++++++
 tb/tb_frwrd_ramp_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/frwrd_ramp_pkg.sv
// Shared types, widths and default constants for the forward-speed ramp controller.
package frwrd_ramp_pkg;

  localparam int FRWRD_W = 10;
  localparam int ERR_W   = 12;

  // Controller phases. IDLE is the only phase where the PID is not qualified.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP_UP = 2'd1,
    CRUISE  = 2'd2,
    RAMP_DN = 2'd3
  } state_e;

  localparam logic [FRWRD_W-1:0] MAX_FRWRD_DEF = 10'h2A0;
  localparam logic [FRWRD_W-1:0] UP_INC_DEF    = 10'd4;
  localparam logic [FRWRD_W-1:0] DN_INC_DEF    = 10'd8;
  localparam logic [ERR_W-1:0]   ERR_HOLD_DEF  = 12'd256;

  // Magnitude of a 12-bit signed error; the most negative code clamps to 2047
  // so the result always fits the unsigned 12-bit compare against ERR_HOLD.
  function automatic logic [ERR_W-1:0] abs_err(input logic [ERR_W-1:0] e);
    logic [ERR_W-1:0] neg;
    neg = ~e + 12'd1;
    if (!e[ERR_W-1]) begin
      abs_err = e;
    end else if (e == 12'h800) begin
      abs_err = 12'h7FF;
    end else begin
      abs_err = neg;
    end
  endfunction

endpackage

// File: rtl/frwrd_ramp_ctrl_sat_step.sv
// Combinational 10-bit saturating step: adds up to a ceiling, or subtracts
// down to zero, selected by dn.
module sat_step
  import frwrd_ramp_pkg::*;
(
  input  logic [FRWRD_W-1:0] a,
  input  logic [FRWRD_W-1:0] step,
  input  logic [FRWRD_W-1:0] ceil,
  input  logic               dn,
  output logic [FRWRD_W-1:0] y
);

  logic [FRWRD_W:0] sum;

  // The up sum is formed one bit wider so a carry out still saturates to ceil.
  always_comb begin
    sum = {1'b0, a} + {1'b0, step};
    y   = '0;
    if (dn) begin
      y = (a > step) ? (a - step) : '0;
    end else begin
      y = (sum > {1'b0, ceil}) ? ceil : sum[FRWRD_W-1:0];
    end
  end

endmodule

// File: rtl/frwrd_ramp_ctrl.sv
// Forward-speed sequencer for the PID steering datapath: ramps frwrd up on
// error samples after go, cruises at a ceiling, ramps down to rest on stop.
//
// Handshake: go and stop are single-cycle command pulses with no ready; stop
// has priority over go whenever both are seen. err_vld is a one-cycle strobe
// qualifying error; every registered update happens on the edge that samples it.
module frwrd_ramp_ctrl
  import frwrd_ramp_pkg::*;
#(
  parameter logic [FRWRD_W-1:0] MAX_FRWRD = MAX_FRWRD_DEF,
  parameter logic [FRWRD_W-1:0] UP_INC    = UP_INC_DEF,
  parameter logic [FRWRD_W-1:0] DN_INC    = DN_INC_DEF,
  parameter logic [ERR_W-1:0]   ERR_HOLD  = ERR_HOLD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               stop,
  input  logic               err_vld,
  input  logic [ERR_W-1:0]   error,
  output logic [FRWRD_W-1:0] frwrd,
  output logic               moving,
  output logic               mv_done
);

  state_e             state_q, state_d;
  logic [FRWRD_W-1:0] frwrd_q, frwrd_d;
  logic               moving_q, moving_d;
  logic               mv_done_q, mv_done_d;

  logic               step_dn;
  logic [FRWRD_W-1:0] step_amt;
  logic [FRWRD_W-1:0] step_y;
  logic               err_hold;

  // A single stepper serves both ramps; direction follows the current phase.
  always_comb begin
    step_dn  = (state_q == RAMP_DN);
    step_amt = step_dn ? DN_INC : UP_INC;
    err_hold = (abs_err(error) >= ERR_HOLD);
  end

  sat_step u_sat_step (
    .a    (frwrd_q),
    .step (step_amt),
    .ceil (MAX_FRWRD),
    .dn   (step_dn),
    .y    (step_y)
  );

  // Next-state and next-output logic; everything defaults to hold, mv_done to 0.
  always_comb begin
    state_d   = state_q;
    frwrd_d   = frwrd_q;
    moving_d  = moving_q;
    mv_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        moving_d = 1'b0;
        if (go && !stop) begin
          state_d  = RAMP_UP;
          moving_d = 1'b1;
        end
      end
      RAMP_UP: begin
        if (stop) begin
          // The stop edge applies no increment even with a sample present.
          state_d = RAMP_DN;
        end else if (err_vld) begin
          if (!err_hold) begin
            frwrd_d = step_y;
          end
          if (frwrd_d == MAX_FRWRD) begin
            state_d = CRUISE;
          end
        end
      end
      CRUISE: begin
        if (stop) begin
          state_d = RAMP_DN;
        end
      end
      RAMP_DN: begin
        if (go && !stop) begin
          // Resume climbing from wherever the ramp-down has reached.
          state_d = RAMP_UP;
        end else if (err_vld) begin
          frwrd_d = step_y;
          if (step_y == '0) begin
            state_d   = IDLE;
            moving_d  = 1'b0;
            mv_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        frwrd_d  = '0;
        moving_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      frwrd_q   <= '0;
      moving_q  <= 1'b0;
      mv_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frwrd_q   <= frwrd_d;
      moving_q  <= moving_d;
      mv_done_q <= mv_done_d;
    end
  end

  assign frwrd   = frwrd_q;
  assign moving  = moving_q;
  assign mv_done = mv_done_q;

endmodule

// File: tb/tb_frwrd_ramp_ctrl.sv
// Bench for frwrd_ramp_ctrl: two instances (ceiling 16 and ceiling 10) share
// one stimulus stream and are compared every cycle against a behavioural model.
module tb_frwrd_ramp_ctrl;
  import frwrd_ramp_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        stop = 1'b0;
  logic        err_vld = 1'b0;
  logic [11:0] error = '0;

  always #5 clk = ~clk;

  logic [9:0] frwrd_a, frwrd_b;
  logic       moving_a, moving_b, mv_done_a, mv_done_b;

  frwrd_ramp_ctrl #(.MAX_FRWRD(10'd16), .UP_INC(10'd4), .DN_INC(10'd8), .ERR_HOLD(12'd256)) dut_a (
    .clk(clk), .rst_n(rst_n), .go(go), .stop(stop), .err_vld(err_vld), .error(error),
    .frwrd(frwrd_a), .moving(moving_a), .mv_done(mv_done_a)
  );

  frwrd_ramp_ctrl #(.MAX_FRWRD(10'd10), .UP_INC(10'd4), .DN_INC(10'd8), .ERR_HOLD(12'd256)) dut_b (
    .clk(clk), .rst_n(rst_n), .go(go), .stop(stop), .err_vld(err_vld), .error(error),
    .frwrd(frwrd_b), .moving(moving_b), .mv_done(mv_done_b)
  );

  // ---------------- reference model ----------------
  int     ceil_of [2] = '{16, 10};
  state_e m_mode  [2];
  int     m_speed [2];
  bit     m_done  [2];

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // One clock edge of the rules, with integer arithmetic.
  task automatic model_edge(input int k, input bit r, input bit g, input bit s,
                            input bit v, input logic [11:0] e);
    int mag;
    mag = $signed(e);
    if (mag < 0) mag = -mag;
    if (mag > 2047) mag = 2047;
    m_done[k] = 0;
    if (!r) begin
      m_mode[k]  = IDLE;
      m_speed[k] = 0;
    end else begin
      case (m_mode[k])
        IDLE:    if (g && !s) m_mode[k] = RAMP_UP;
        RAMP_UP: begin
          if (s) m_mode[k] = RAMP_DN;
          else if (v) begin
            if (mag < 256) m_speed[k] = (m_speed[k] + 4 > ceil_of[k]) ? ceil_of[k] : m_speed[k] + 4;
            if (m_speed[k] == ceil_of[k]) m_mode[k] = CRUISE;
          end
        end
        CRUISE:  if (s) m_mode[k] = RAMP_DN;
        default: begin
          if (g && !s) m_mode[k] = RAMP_UP;
          else if (v) begin
            if (m_speed[k] > 8) m_speed[k] = m_speed[k] - 8;
            else begin
              m_speed[k] = 0;
              m_done[k]  = 1;
              m_mode[k]  = IDLE;
            end
          end
        end
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a_frwrd",   32'(frwrd_a),   32'(m_speed[0]));
    check("a_moving",  32'(moving_a),  32'(m_mode[0] != IDLE));
    check("a_mv_done", 32'(mv_done_a), 32'(m_done[0]));
    check("a_state",   32'(dut_a.state_q), 32'(m_mode[0]));
    check("b_frwrd",   32'(frwrd_b),   32'(m_speed[1]));
    check("b_moving",  32'(moving_b),  32'(m_mode[1] != IDLE));
    check("b_mv_done", 32'(mv_done_b), 32'(m_done[1]));
    check("b_state",   32'(dut_b.state_q), 32'(m_mode[1]));
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit r, input bit g, input bit s, input bit v, input logic [11:0] e);
    @(negedge clk);
    rst_n = r; go = g; stop = s; err_vld = v; error = e;
    for (int k = 0; k < 2; k++) model_edge(k, r, g, s, v, e);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_c();               cyc(1, 0, 0, 0, 12'd0); endtask
  task automatic go_c();                 cyc(1, 1, 0, 0, 12'd0); endtask
  task automatic stop_c();               cyc(1, 0, 1, 0, 12'd0); endtask
  task automatic smp(input logic [11:0] e); cyc(1, 0, 0, 1, e); endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = IDLE; m_speed[k] = 0; m_done[k] = 0;
    end
    cyc(0, 0, 0, 0, 12'd0);
    cyc(0, 0, 0, 0, 12'd0);
    check("reset_frwrd", 32'(frwrd_a), 32'd0);

    // reset mid-ramp, then a sample with no go
    go_c(); smp(12'd10); smp(12'd10);
    check("pre_reset_frwrd", 32'(frwrd_a), 32'd8);
    cyc(0, 0, 0, 1, 12'd10);
    check("mid_reset_moving", 32'(moving_a), 32'd0);
    smp(12'd10);
    check("no_go_frwrd", 32'(frwrd_a), 32'd0);

    // ramp up to ceiling; B saturates at 10
    go_c();
    check("go_moving", 32'(moving_a), 32'd1);
    repeat (4) smp(12'd10);
    check("a_cruise_frwrd", 32'(frwrd_a), 32'd16);
    check("b_sat_frwrd", 32'(frwrd_b), 32'd10);
    smp(12'd10);
    go_c();

    // error hold, including the -2048 corner and the 255 edge
    cyc(0, 0, 0, 0, 12'd0);
    go_c(); smp(12'd10); smp(12'd10);
    smp(-12'sd300); smp(12'h800); smp(12'd256); smp(12'd255);
    check("hold_release_frwrd", 32'(frwrd_a), 32'd12);
    smp(12'd10);

    // ramp down: mv_done with moving falling
    stop_c(); smp(12'd5); smp(12'd5);
    check("dn_done", 32'(mv_done_a), 32'd1);
    idle_c();

    // resume from RAMP_DN and stop-with-sample edge
    go_c(); repeat (4) smp(12'd1);
    stop_c(); smp(12'd1); go_c(); smp(12'd1);
    check("resume_frwrd", 32'(frwrd_a), 32'd12);
    cyc(1, 0, 1, 1, 12'd1);
    check("stop_no_inc", 32'(frwrd_a), 32'd12);
    repeat (3) smp(12'd1);
    cyc(1, 1, 1, 0, 12'd0);
    check("go_stop_idle", 32'(moving_a), 32'd0);
    cyc(1, 1, 1, 1, 12'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit r, g, s, v;
      logic [11:0] e;
      r = ($urandom_range(0, 149) != 0);
      g = ($urandom_range(0, 11) == 0);
      s = ($urandom_range(0, 19) == 0);
      v = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: e = 12'($signed($urandom_range(0, 400)) - 200);
        1: e = $urandom_range(0, 1) ? 12'($urandom_range(250, 260)) : 12'(-$signed($urandom_range(250, 260)));
        2: e = 12'($urandom);
        default: e = 12'h800;
      endcase
      cyc(r, g, s, v, e);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
